qq_dequeue_reader: RTL

Dequeue-side reader for the QuickQ priority queue. It holds the current maximum in a head register and serves pops through a request/valid handshake. After each pop it refills the head from the descending-sorted BRAM overflow region, a 1-cycle synchronous-read BRAM owned by the enqueue side. It is the read-side counterpart of the enqueue path's reg-vs-BRAM comparison/routing logic, and it exports the head value so the enqueue side can compare against it.

---
 rtl/qq_dequeue_reader.sv | 105 ++++++++++
 1 files changed

// File: rtl/qq_dequeue_reader.sv
// Dequeue-side reader for the QuickQ priority queue: keeps the current maximum
// in a head register and refills it from the descending-sorted BRAM overflow ring.
module qq_dequeue_reader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              deq_req,
    output logic              deq_ready,
    output logic              deq_valid,
    output logic [DATA_W-1:0] deq_data,
    output logic              empty,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    input  logic [ADDR_W:0]   ram_count,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] rd_ptr
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   rd_ptr_reg;
    logic [DATA_W-1:0]   head_reg;
    logic [DATA_W-1:0]   deq_data_reg;
    logic                deq_valid_reg;
    logic                rd_issue;
    logic                pop;
    logic                ram_has_data;

    assign ram_has_data = (ram_count != '0);
    assign pop          = (state_reg == ST_FULL) && deq_req;

    always_comb begin
        state_next = state_reg;
        rd_issue   = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (ram_has_data) begin
                    rd_issue   = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_FULL;
            end
            ST_FULL: begin
                if (deq_req) begin
                    if (ram_has_data) begin
                        rd_issue   = 1'b1;
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // The read is issued combinationally so the BRAM data lands during the single LOAD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            rd_ptr_reg    <= '0;
            head_reg      <= '0;
            deq_data_reg  <= '0;
            deq_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            deq_valid_reg <= pop;
            if (rd_issue) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            if (state_reg == ST_LOAD) begin
                head_reg <= ram_data;
            end
            if (pop) begin
                deq_data_reg <= head_reg;
            end
        end
    end

    assign ram_en     = rd_issue && !rst;
    assign ram_addr   = rd_ptr_reg;
    assign rd_ptr     = rd_ptr_reg;
    assign deq_ready  = (state_reg == ST_FULL);
    assign head_valid = (state_reg == ST_FULL);
    assign head_data  = head_reg;
    assign deq_valid  = deq_valid_reg;
    assign deq_data   = deq_data_reg;
    assign empty      = (state_reg == ST_EMPTY) && !ram_has_data;

endmodule
